// File: rtl/bsg_dmc_ui_arbiter_if.sv
// bsg_dmc_ui_arbiter_if: requester-side and DMC app-side signals of the UI arbiter.
// slave is the arbiter's view, master is the surrounding environment's view.
interface bsg_dmc_ui_arbiter_if #(
  parameter int num_req_p = 4,
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 64
);
  localparam int mask_lp = ui_data_width_p / 8;
  logic [num_req_p-1:0] req_v_i, req_yumi_o, req_wdata_v_i, req_wdata_yumi_o, rd_v_o;
  logic [3*num_req_p-1:0] req_cmd_i;
  logic [ui_addr_width_p*num_req_p-1:0] req_addr_i;
  logic [ui_data_width_p*num_req_p-1:0] req_wdata_i;
  logic [mask_lp*num_req_p-1:0] req_wmask_i;
  logic [ui_data_width_p-1:0] rd_data_o, app_wdf_data_o, app_rd_data_i;
  logic [ui_addr_width_p-1:0] app_addr_o;
  logic [2:0] app_cmd_o;
  logic [mask_lp-1:0] app_wdf_mask_o;
  logic rd_end_o, app_en_o, app_rdy_i, app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
  logic app_rd_data_valid_i, app_rd_data_end_i, tag_err_o;
  modport slave (
    input req_v_i, req_cmd_i, req_addr_i, req_wdata_v_i, req_wdata_i, req_wmask_i,
    input app_rdy_i, app_wdf_rdy_i, app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i,
    output req_yumi_o, req_wdata_yumi_o, rd_v_o, rd_data_o, rd_end_o,
    output app_addr_o, app_cmd_o, app_en_o, app_wdf_wren_o, app_wdf_data_o,
    output app_wdf_mask_o, app_wdf_end_o, tag_err_o
  );
  modport master (
    output req_v_i, req_cmd_i, req_addr_i, req_wdata_v_i, req_wdata_i, req_wmask_i,
    output app_rdy_i, app_wdf_rdy_i, app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i,
    input req_yumi_o, req_wdata_yumi_o, rd_v_o, rd_data_o, rd_end_o,
    input app_addr_o, app_cmd_o, app_en_o, app_wdf_wren_o, app_wdf_data_o,
    input app_wdf_mask_o, app_wdf_end_o, tag_err_o
  );
endinterface

// File: rtl/bsg_dmc_ui_arbiter.sv
// bsg_dmc_ui_arbiter: round-robin sharing of one DMC app interface among requesters,
// with a tag FIFO routing in-order read bursts back to their owners.
module bsg_dmc_ui_arbiter #(
  parameter int num_req_p = 4,
  parameter int ui_addr_width_p = 28,
  parameter int ui_data_width_p = 64,
  parameter int burst_data_width_p = 256,
  parameter int tag_fifo_depth_p = 8
) (
  input logic ui_clk_i,
  input logic reset_i,
  bsg_dmc_ui_arbiter_if.slave ui
);
  localparam int mask_lp = ui_data_width_p / 8;
  localparam int beats_lp = burst_data_width_p / ui_data_width_p;
  localparam int idx_w = $clog2(num_req_p);
  localparam int cnt_w = beats_lp > 1 ? $clog2(beats_lp) : 1;
  localparam int ptr_w = tag_fifo_depth_p > 1 ? $clog2(tag_fifo_depth_p) : 1;
  localparam int fcnt_w = $clog2(tag_fifo_depth_p + 1);

  typedef enum logic [1:0] {IDLE, WDATA, CMD} state_e;
  state_e state_q, state_d;
  logic [idx_w-1:0] rr_q, rr_d, g_q, g_d, gnt_idx, head;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [ptr_w-1:0] wp_q, rp_q;
  logic [fcnt_w-1:0] fcnt_q;
  logic [idx_w-1:0] tag_q [tag_fifo_depth_p];
  logic [num_req_p-1:0] elig, g_oh, head_oh;
  logic rd_q, rd_d, gnt_v, err_q, full, empty, in_w, in_c, beat, last, push, pop;

  assign full = fcnt_q == fcnt_w'(tag_fifo_depth_p);
  assign empty = fcnt_q == '0;
  assign head = tag_q[rp_q];
  assign in_w = state_q == WDATA;
  assign in_c = state_q == CMD;
  assign g_oh = num_req_p'(1) << g_q;
  assign head_oh = num_req_p'(1) << head;
  assign beat = in_w && ui.req_wdata_v_i[g_q] && ui.app_wdf_rdy_i;
  assign last = cnt_q == cnt_w'(beats_lp - 1);
  assign push = in_c && ui.app_rdy_i && rd_q;
  assign pop = ui.app_rd_data_valid_i && ui.app_rd_data_end_i && !empty;
  assign ui.tag_err_o = err_q;

  // Grants happen only from IDLE, so no read grant is in flight when eligibility is evaluated
  for (genvar i = 0; i < num_req_p; i++) begin : g_elig
    assign elig[i] = ui.req_v_i[i] && !(ui.req_cmd_i[3*i] && full);
  end

  // Descending scan so the nearest eligible index after rr_q wins
  always_comb begin
    gnt_v = 1'b0;
    gnt_idx = '0;
    for (int k = num_req_p; k >= 1; k--)
      if (elig[(int'(rr_q) + k) % num_req_p]) begin
        gnt_v = 1'b1;
        gnt_idx = idx_w'((int'(rr_q) + k) % num_req_p);
      end
  end

  always_ff @(posedge ui_clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      rr_q <= idx_w'(num_req_p - 1);
      g_q <= '0;
      rd_q <= 1'b0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      fcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      g_q <= g_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q == ptr_w'(tag_fifo_depth_p - 1) ? '0 : wp_q + ptr_w'(1);
      if (pop) rp_q <= rp_q == ptr_w'(tag_fifo_depth_p - 1) ? '0 : rp_q + ptr_w'(1);
      fcnt_q <= fcnt_q + fcnt_w'(push) - fcnt_w'(pop);
      err_q <= err_q | (ui.app_rd_data_valid_i && empty);
    end

  always_ff @(posedge ui_clk_i)
    if (push) tag_q[wp_q] <= g_q;

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    g_d = g_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE:
        if (gnt_v) begin
          g_d = gnt_idx;
          rr_d = gnt_idx;
          rd_d = ui.req_cmd_i[3*gnt_idx];
          state_d = rd_d ? CMD : WDATA;
        end
      WDATA:
        if (beat) begin
          cnt_d = last ? '0 : cnt_q + cnt_w'(1);
          state_d = last ? CMD : WDATA;
        end
      CMD: state_d = ui.app_rdy_i ? IDLE : CMD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ui.app_en_o = in_c;
    ui.app_addr_o = in_c ? ui.req_addr_i[g_q*ui_addr_width_p +: ui_addr_width_p] : '0;
    ui.app_cmd_o = in_c ? ui.req_cmd_i[3*g_q +: 3] : '0;
    ui.req_yumi_o = in_c && ui.app_rdy_i ? g_oh : '0;
    ui.app_wdf_wren_o = in_w && ui.req_wdata_v_i[g_q];
    ui.app_wdf_data_o = in_w ? ui.req_wdata_i[g_q*ui_data_width_p +: ui_data_width_p] : '0;
    ui.app_wdf_mask_o = in_w ? ui.req_wmask_i[g_q*mask_lp +: mask_lp] : '0;
    ui.app_wdf_end_o = ui.app_wdf_wren_o && last;
    ui.req_wdata_yumi_o = beat ? g_oh : '0;
    ui.rd_v_o = ui.app_rd_data_valid_i && !empty ? head_oh : '0;
    ui.rd_data_o = ui.app_rd_data_i;
    ui.rd_end_o = ui.app_rd_data_valid_i && ui.app_rd_data_end_i;
  end
endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// tb_bsg_dmc_ui_arbiter: scoreboard bench; expected commands, write beats and read owners
// are queued when stimulus is driven and compared as the DMC side sees them.
module tb_bsg_dmc_ui_arbiter;
  localparam int N = 4, AW = 28, DW = 64, MW = 8, BEATS = 4, DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  bsg_dmc_ui_arbiter_if #(.num_req_p(N), .ui_addr_width_p(AW), .ui_data_width_p(DW)) ui();
  bsg_dmc_ui_arbiter #(
    .num_req_p(N), .ui_addr_width_p(AW), .ui_data_width_p(DW),
    .burst_data_width_p(256), .tag_fifo_depth_p(DEPTH)
  ) dut (.ui_clk_i(clk), .reset_i(rst), .ui(ui));

  typedef struct packed {logic [1:0] r; logic [2:0] cmd; logic [AW-1:0] addr;} cmd_t;
  typedef struct packed {logic [1:0] r; logic [DW-1:0] d; logic [MW-1:0] m; logic e;} beat_t;
  cmd_t cq[$];
  beat_t bq[$];
  int rq[$];
  int total = 0, bad = 0;
  int wb[N], yc[N];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wd(int r, int k);
    return {32'(r) + 32'hCAFE0000, 32'(k) * 32'h11111111 + 32'h5};
  endfunction

  function automatic logic [MW-1:0] wm(int r, int k);
    return 8'(r * 16 + k + 1);
  endfunction

  task automatic set_wdata(int i);
    ui.req_wdata_i[i*DW +: DW] = wd(i, wb[i]);
    ui.req_wmask_i[i*MW +: MW] = wm(i, wb[i]);
  endtask

  task automatic issue_write(int r, logic [AW-1:0] a);
    for (int k = 0; k < BEATS; k++)
      bq.push_back('{r: 2'(r), d: wd(r, k), m: wm(r, k), e: (k == BEATS - 1)});
    cq.push_back('{r: 2'(r), cmd: 3'b000, addr: a});
    ui.req_cmd_i[3*r +: 3] = 3'b000;
    ui.req_addr_i[r*AW +: AW] = a;
    wb[r] = 0;
    set_wdata(r);
    ui.req_wdata_v_i[r] = 1'b1;
    ui.req_v_i[r] = 1'b1;
  endtask

  task automatic issue_read(int r, logic [AW-1:0] a, bit expect_it);
    if (expect_it) cq.push_back('{r: 2'(r), cmd: 3'b001, addr: a});
    ui.req_cmd_i[3*r +: 3] = 3'b001;
    ui.req_addr_i[r*AW +: AW] = a;
    ui.req_v_i[r] = 1'b1;
  endtask

  task automatic wait_drain(bit tog);
    int n = 0;
    while ((cq.size() != 0 || bq.size() != 0) && n < 200) begin
      @(posedge clk); #2;
      if (tog) ui.app_wdf_rdy_i = ~ui.app_wdf_rdy_i;
      n++;
    end
    ui.app_wdf_rdy_i = 1'b1;
    check("drain", 64'(cq.size() + bq.size()), 0);
  endtask

  task automatic ret_burst();
    int o;
    logic [DW-1:0] d;
    check("rq_ready", 64'(rq.size() > 0), 1);
    if (rq.size() == 0) return;
    o = rq[0];
    for (int k = 0; k < BEATS; k++) begin
      @(posedge clk); #1;
      d = {$urandom, $urandom};
      ui.app_rd_data_valid_i = 1'b1;
      ui.app_rd_data_i = d;
      ui.app_rd_data_end_i = (k == BEATS - 1);
      @(negedge clk);
      check("rd_v", ui.rd_v_o, N'(1) << o);
      check("rd_data", ui.rd_data_o, d);
      check("rd_end", ui.rd_end_o, k == BEATS - 1);
    end
    @(posedge clk); #1;
    ui.app_rd_data_valid_i = 1'b0;
    ui.app_rd_data_end_i = 1'b0;
    void'(rq.pop_front());
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_en"}, ui.app_en_o, 0);
    check({tag, "_addr"}, ui.app_addr_o, 0);
    check({tag, "_wren"}, ui.app_wdf_wren_o, 0);
    check({tag, "_wdata"}, ui.app_wdf_data_o, 0);
    check({tag, "_wend"}, ui.app_wdf_end_o, 0);
    check({tag, "_yumi"}, ui.req_yumi_o, 0);
    check({tag, "_wyumi"}, ui.req_wdata_yumi_o, 0);
    check({tag, "_rdv"}, ui.rd_v_o, 0);
    check({tag, "_err"}, ui.tag_err_o, 0);
  endtask

  // DMC-side monitor: compares accepted commands and beats, then retires requester state
  initial begin
    forever begin : mon
      logic [N-1:0] cy, wy;
      cmd_t ce;
      beat_t be;
      cy = '0;
      wy = '0;
      @(negedge clk);
      if (!rst) begin
        if (ui.app_en_o && ui.app_rdy_i) begin
          cy = ui.req_yumi_o;
          if (cq.size() == 0) check("cmd_unexp", ui.app_en_o, 0);
          else begin
            ce = cq.pop_front();
            check("cmd_op", ui.app_cmd_o, ce.cmd);
            check("cmd_addr", ui.app_addr_o, ce.addr);
            check("cmd_yumi", ui.req_yumi_o, N'(1) << ce.r);
            if (ce.cmd[0]) rq.push_back(int'(ce.r));
          end
        end else if (ui.req_yumi_o != '0) check("yumi_spur", ui.req_yumi_o, 0);
        if (ui.app_wdf_wren_o && ui.app_wdf_rdy_i) begin
          wy = ui.req_wdata_yumi_o;
          if (bq.size() == 0) check("wbeat_unexp", ui.app_wdf_wren_o, 0);
          else begin
            be = bq.pop_front();
            check("wdata", ui.app_wdf_data_o, be.d);
            check("wmask", ui.app_wdf_mask_o, be.m);
            check("wend", ui.app_wdf_end_o, be.e);
            check("wyumi", ui.req_wdata_yumi_o, N'(1) << be.r);
          end
        end else if (ui.req_wdata_yumi_o != '0) check("wyumi_spur", ui.req_wdata_yumi_o, 0);
        for (int i = 0; i < N; i++) if (wy[i]) yc[i]++;
      end
      @(posedge clk); #1;
      if (!rst)
        for (int i = 0; i < N; i++) begin
          if (cy[i]) ui.req_v_i[i] = 1'b0;
          if (wy[i]) begin
            wb[i]++;
            if (wb[i] == BEATS) ui.req_wdata_v_i[i] = 1'b0;
            else set_wdata(i);
          end
        end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ui.req_v_i = '0; ui.req_cmd_i = '0; ui.req_addr_i = '0;
    ui.req_wdata_v_i = '0; ui.req_wdata_i = '0; ui.req_wmask_i = '0;
    ui.app_rdy_i = 1'b1; ui.app_wdf_rdy_i = 1'b1;
    ui.app_rd_data_valid_i = 1'b0; ui.app_rd_data_i = '0; ui.app_rd_data_end_i = 1'b0;
    for (int i = 0; i < N; i++) begin wb[i] = 0; yc[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    @(posedge clk); #2;
    rst = 1'b0;

    // two rounds of all-requester reads: pointer starts at N-1, so order 0,1,2,3
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int r = 0; r < N; r++) issue_read(r, 28'h400 + 28'(r * 16 + rnd), 1'b1);
      wait_drain(1'b0);
      for (int r = 0; r < N; r++) ret_burst();
    end

    issue_read(2, 28'h100, 1'b1);
    wait_drain(1'b0);
    ret_burst();

    // pointer now at 2: requester 3 must win over requester 1
    issue_read(3, 28'h333, 1'b1);
    issue_read(1, 28'h111, 1'b1);
    wait_drain(1'b0);
    ret_burst();
    ret_burst();

    // write with toggling wdf_rdy; requester 3 offers stray beats that must never be taken
    for (int i = 0; i < N; i++) yc[i] = 0;
    ui.req_wdata_i[3*DW +: DW] = 64'hDEAD;
    ui.req_wdata_v_i[3] = 1'b1;
    issue_write(0, 28'h200);
    wait_drain(1'b1);
    check("wr_beats", 64'(yc[0]), BEATS);
    check("stray_beats", 64'(yc[3]), 0);
    ui.req_wdata_v_i[3] = 1'b0;

    // fill the tag FIFO, then a read stays blocked while a write is still served
    for (int k = 0; k < DEPTH; k++) begin
      issue_read(k % N, 28'h1000 + 28'(k * 64), 1'b1);
      wait_drain(1'b0);
    end
    check("rq_full", 64'(rq.size()), DEPTH);
    issue_read(0, 28'h900, 1'b0);
    issue_write(1, 28'h500);
    wait_drain(1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("full_en", ui.app_en_o, 0);
    check("full_yumi", ui.req_yumi_o, 0);
    @(posedge clk); #2;
    cq.push_back('{r: 2'd0, cmd: 3'b001, addr: 28'h900});
    ret_burst();
    wait_drain(1'b0);
    check("rq_refill", 64'(rq.size()), DEPTH);
    for (int k = 0; k < DEPTH; k++) ret_burst();

    // read data with no outstanding tag
    @(negedge clk);
    check("err_pre", ui.tag_err_o, 0);
    @(posedge clk); #1;
    ui.app_rd_data_valid_i = 1'b1;
    ui.app_rd_data_end_i = 1'b1;
    ui.app_rd_data_i = 64'h1234;
    @(negedge clk);
    check("orphan_rdv", ui.rd_v_o, 0);
    @(posedge clk); #1;
    ui.app_rd_data_valid_i = 1'b0;
    ui.app_rd_data_end_i = 1'b0;
    @(negedge clk);
    check("err_set", ui.tag_err_o, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err_sticky", ui.tag_err_o, 1);

    // asynchronous reset after two accepted beats of a write
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) yc[i] = 0;
    issue_write(0, 28'h700);
    for (int n = 0; n < 50 && yc[0] < 2; n++) begin @(posedge clk); #2; end
    check("pre_rst_beats", 64'(yc[0]), 2);
    rst = 1'b1;
    #1;
    check_idle_outputs("arst");
    cq.delete(); bq.delete(); rq.delete();
    ui.req_v_i = '0;
    ui.req_wdata_v_i = '0;
    for (int i = 0; i < N; i++) begin wb[i] = 0; yc[i] = 0; end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    issue_write(0, 28'h740);
    wait_drain(1'b0);
    check("post_rst_beats", 64'(yc[0]), BEATS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bsg_dmc_ui_arbiter.md
Name: bsg_dmc_ui_arbiter

Overview:
- Shares one bsg_dmc user (app_*) interface among num_req_p requesters; sits in the ui_clk_i domain in front of the DMC controller.
- Round-robin arbitration at transaction granularity; a granted write owns the interface until all its burst beats and its command are issued.
- Read responses return in order; a tag FIFO of requester ids routes each returning burst to its owner.

Parameters:
- num_req_p, 4, number of requesters (>=2)
- ui_addr_width_p, 28, app address width
- ui_data_width_p, 64, app data width; mask width = ui_data_width_p/8
- burst_data_width_p, 256, bytes-per-transaction*8; beats_lp = burst_data_width_p/ui_data_width_p (>=1)
- tag_fifo_depth_p, 8, max outstanding reads

Ports:
- ui_clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- req_v_i  in  num_req_p  per-requester command valid
- req_cmd_i  in  3*num_req_p  app_cmd_e per requester (bit0=1: read, else write)
- req_addr_i  in  ui_addr_width_p*num_req_p  address per requester
- req_yumi_o  out  num_req_p  command consumed (one-hot or zero)
- req_wdata_v_i  in  num_req_p  write beat valid
- req_wdata_i  in  ui_data_width_p*num_req_p  write beat data
- req_wmask_i  in  (ui_data_width_p/8)*num_req_p  write beat mask
- req_wdata_yumi_o  out  num_req_p  write beat consumed
- rd_v_o  out  num_req_p  read beat valid, one-hot to owner
- rd_data_o  out  ui_data_width_p  read beat data (broadcast)
- rd_end_o  out  1  last beat of a read burst
- app_addr_o, app_cmd_o, app_en_o  out  ui_addr_width_p/3/1  to DMC
- app_rdy_i  in  1
- app_wdf_wren_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o  out  1/ui_data_width_p/mask/1
- app_wdf_rdy_i  in  1
- app_rd_data_valid_i, app_rd_data_i, app_rd_data_end_i  in  1/ui_data_width_p/1
- tag_err_o  out  1  sticky: read data arrived with empty tag FIFO

Behaviour:
- Reset: state IDLE, rr pointer = num_req_p-1, beat counter 0, tag FIFO empty, tag_err_o 0; all valid/enable/yumi outputs 0, data/addr outputs 0.
- Eligibility: req_v_i[i] && !(read && tag FIFO full). Among eligible, grant first index after rr pointer (wrapping). Grant registered in IDLE; rr pointer <= granted index. IDLE with no eligible stays IDLE.
- IDLE -> WDATA (write) or CMD (read), 1 cycle arbitration latency.
- WDATA: app_wdf_wren_o = req_wdata_v_i[g]; data/mask muxed from g; req_wdata_yumi_o[g] = req_wdata_v_i[g] & app_wdf_rdy_i. Counter increments per accepted beat; app_wdf_end_o = (counter==beats_lp-1). On accepted end beat: counter<=0, -> CMD.
- CMD: app_en_o=1, addr/cmd from g (held for requester's values; requester must hold req_* stable until yumi). On app_rdy_i: req_yumi_o[g]=1 that cycle; if read, push g into tag FIFO; -> IDLE.
- Read return combinational: rd_v_o = app_rd_data_valid_i ? onehot(fifo head) : 0; rd_data_o = app_rd_data_i; rd_end_o = app_rd_data_valid_i & app_rd_data_end_i. Pop on valid & end.
- Push and pop in same cycle allowed, including when full (full never blocks pop; push only reached when not full at grant, counted including reservation: eligibility uses count of outstanding + in-flight read grant).
- Valid read data with empty FIFO: rd_v_o=0, beat dropped, tag_err_o set until reset.
- Write beats ahead of command per DMC UI rule; requester beats outside WDATA of its grant are never consumed.
- Reset asserted mid-transaction: immediate return to reset state; outstanding read tags discarded.

Test Plan:
- Single read, req 2, addr 0x100, 4-beat return -> app_en_o with app_cmd_o=1, addr 0x100; rd_v_o=0b0100 for 4 beats, rd_end_o on 4th only.
- Write, req 0, beats_lp=4, app_wdf_rdy_i toggling 1,0,1,... -> exactly 4 wdata yumis, app_wdf_end_o only on 4th, then one app_en_o with cmd 0.
- All 4 requesters valid continuously with reads -> grant order 0,1,2,3,0...; responses routed in same order.
- tag_fifo_depth_p=8, 8 reads issued, no return -> 9th read never granted, writes still granted; one returned burst end -> read granted next arbitration.
- app_rd_data_valid_i with empty FIFO -> rd_v_o=0, tag_err_o=1 sticky.
- reset_i pulsed mid-WDATA after 2 beats -> all outputs 0 asynchronously; next write restarts at beat 0 with end on 4th beat.
